prog_run_ctrl: RTL and testbench
================================

PROG_RUN_CTRL -- requirements
Module: prog_run_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- ADDR_W, 8, width of program start address.
- NUM_PROGS, 4, number of program table slots; IDX_W = $clog2(NUM_PROGS), minimum 1.
- CNT_W, 32, width of the cycle and instruction counters.
- TIMEOUT, 20000, maximum RUN cycles before a program is abandoned.
- START_LEN, 1, number of cycles `start` is held high per launch (minimum 1).

REQ-002 The block SHALL have these ports:
- CLK, input, 1, single clock; all state on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- cfg_we, input, 1, program table write strobe.
- cfg_idx, input, IDX_W, table slot to write.
- cfg_addr, input, ADDR_W, start address written to that slot.
- go, input, 1, begin a run (sampled in IDLE only).
- run_all, input, 1, sampled with go: 1 = run slots 0..NUM_PROGS-1 in order; 0 = run slot run_sel only.
- run_sel, input, IDX_W, slot run when run_all=0.
- abort, input, 1, cancel the current run.
- halt, input, 1, core finished flag.
- instr_retire, input, 1, one-cycle pulse per retired core instruction.
- start, output, 1, core start/reset pulse.
- start_addr, output, ADDR_W, core start PC.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse when a run sequence completes.
- res_valid, output, 1, one-cycle pulse per finished program.
- res_idx, output, IDX_W, slot of the reported result.
- res_cycles, output, CNT_W, RUN cycle count of the reported program.
- res_instrs, output, CNT_W, retired-instruction count of the reported program.
- res_timeout, output, 1, reported program hit TIMEOUT.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, LAUNCH, RUN, REPORT, FIN.
REQ-004 In IDLE, cfg_we SHALL write cfg_addr into table[cfg_idx] on the clock edge; cfg_we SHALL be ignored in every other state.
REQ-005 In IDLE, go=1 SHALL latch run_all, set cur = (run_all ? 0 : run_sel), and move to LAUNCH; go SHALL be ignored in all other states.
REQ-006 LAUNCH behaviour:
- start=1 for exactly START_LEN cycles.
- start_addr=table[cur].
- The cycle and instruction counters SHALL be cleared.
- The state SHALL then move to RUN.
REQ-007 Outside LAUNCH, start SHALL be 0 and start_addr SHALL hold its last driven value.
REQ-008 In RUN, the cycle counter SHALL increment by 1 every cycle, with the first RUN cycle counting as 1.
REQ-009 The instruction counter SHALL increment on each instr_retire sampled in RUN; instr_retire SHALL be ignored outside RUN.
REQ-010 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-011 halt SHALL be sampled only in RUN; halt=1 SHALL move the FSM to REPORT with res_timeout=0.
REQ-012 If the cycle count equals TIMEOUT with halt=0, the FSM SHALL move to REPORT with res_timeout=1.
REQ-013 If halt and the timeout condition occur in the same cycle, halt SHALL win and res_timeout SHALL be 0.
REQ-014 The REPORT state SHALL last one cycle:
- res_valid=1.
- res_idx=cur, and res_cycles/res_instrs equal the final counter values.
- res_idx, res_cycles, res_instrs and res_timeout SHALL hold until the next REPORT.
REQ-015 After REPORT, the FSM SHALL select the next step as follows:
- If run_all is latched and cur < NUM_PROGS-1: cur increments and the FSM returns to LAUNCH.
- Otherwise the FSM moves to FIN.
REQ-016 FIN SHALL pulse done=1 for one cycle and return to IDLE.
REQ-017 abort=1 in LAUNCH or RUN SHALL move the FSM to IDLE on the next edge, with no res_valid, no done, and start deasserted immediately.
REQ-018 abort SHALL be ignored in REPORT and FIN.
REQ-019 busy SHALL be 0 in IDLE and 1 in LAUNCH, RUN, REPORT and FIN.

Reset
REQ-020 reset_n=0 SHALL asynchronously force all of the following, regardless of state, including mid-run:
- FSM to IDLE and cur=0.
- All table entries to 0.
- Both counters to 0.
- start=0, start_addr=0, busy=0, done=0, res_valid=0, res_idx=0, res_cycles=0, res_instrs=0, res_timeout=0.
REQ-021 The first clock edge after reset_n rises SHALL be treated as an IDLE cycle.

Verification
REQ-022 Single run: table[1]=8'd75, run_all=0, run_sel=1, go; halt 10 RUN cycles later with 7 retire pulses
-> start high 1 cycle with start_addr=75; res_valid pulse with res_idx=1, res_cycles=10, res_instrs=7, res_timeout=0; done one cycle later.
REQ-023 Sweep: table={0,75,130,200}, run_all=1, halts after 5/6/7/8 RUN cycles
-> 4 launches in order 0,75,130,200; 4 res_valid pulses with res_cycles 5,6,7,8; a single done pulse after the last.
REQ-024 Timeout: TIMEOUT=50, halt never asserted
-> res_valid with res_timeout=1, res_cycles=50.
-> Separate case: halt first seen on RUN cycle 50 -> res_timeout=0.
REQ-025 Abort and config lockout: abort on RUN cycle 3 -> IDLE, no res_valid, no done.
-> cfg_we during busy leaves the table unchanged.
-> go during busy is ignored.
REQ-026 Reset mid-run: reset_n low during RUN with counters nonzero
-> all outputs 0 immediately, without waiting for a clock edge; a subsequent go starts a fresh run.

Source files
------------

// File: rtl/prog_run_ctrl.sv
// Program-run sequencer: launches a core from a small start-address table,
// measures each run (cycles, retired instructions) and reports per-program results.
module prog_run_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int NUM_PROGS = 4,
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = 20000,
  parameter int START_LEN = 1,
  localparam int IDX_W    = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              go,
  input  logic              run_all,
  input  logic [IDX_W-1:0]  run_sel,
  input  logic              abort,
  input  logic              halt,
  input  logic              instr_retire,
  output logic              start,
  output logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx,
  output logic [CNT_W-1:0]  res_cycles,
  output logic [CNT_W-1:0]  res_instrs,
  output logic              res_timeout
);

  // state  | meaning
  // IDLE   | waiting for go; program table writable
  // LAUNCH | start pulse to core, counters cleared
  // RUN    | core executing; counting cycles and retired instructions
  // REPORT | one-cycle result pulse for slot cur
  // FIN    | one-cycle done pulse, back to IDLE
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, REPORT, FIN} state_t;

  localparam int SL_W = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam logic [SL_W-1:0]  SL_LOAD  = SL_W'(START_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] prog_tab [2**IDX_W];
  logic [IDX_W-1:0]  cur;
  logic              all_q;
  logic [SL_W-1:0]   slen_cnt;
  logic [CNT_W-1:0]  cyc_cnt, ins_cnt, cyc_inc, ins_inc;
  logic [ADDR_W-1:0] addr_q;
  logic              timeout_hit;

  // cyc_inc is the count including the current RUN cycle, so the first RUN cycle reads as 1
  assign cyc_inc     = (cyc_cnt == CNT_MAX) ? cyc_cnt : cyc_cnt + CNT_W'(1);
  assign ins_inc     = (instr_retire && (ins_cnt != CNT_MAX)) ? ins_cnt + CNT_W'(1) : ins_cnt;
  assign timeout_hit = (cyc_inc == TO_CNT);
  assign start_addr  = (state == LAUNCH) ? prog_tab[cur] : addr_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    res_valid = 1'b0;
    if (state != IDLE) busy = 1'b1;
    case (state)
      IDLE: begin
        if (go) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        start = !abort;
        if (abort)                 state_nxt = IDLE;
        else if (slen_cnt == '0)   state_nxt = RUN;
      end
      RUN: begin
        if (abort)                     state_nxt = IDLE;
        else if (halt || timeout_hit)  state_nxt = REPORT;
      end
      REPORT: begin
        res_valid = 1'b1;
        if (all_q && (cur < LAST_IDX)) state_nxt = LAUNCH;
        else                           state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**IDX_W; i++) prog_tab[i] <= '0;
      cur         <= '0;
      all_q       <= 1'b0;
      slen_cnt    <= '0;
      cyc_cnt     <= '0;
      ins_cnt     <= '0;
      addr_q      <= '0;
      res_idx     <= '0;
      res_cycles  <= '0;
      res_instrs  <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we) prog_tab[cfg_idx] <= cfg_addr;
          if (go) begin
            all_q    <= run_all;
            cur      <= run_all ? '0 : run_sel;
            slen_cnt <= SL_LOAD;
          end
        end
        LAUNCH: begin
          cyc_cnt <= '0;
          ins_cnt <= '0;
          addr_q  <= prog_tab[cur];
          if (slen_cnt != '0) slen_cnt <= slen_cnt - SL_W'(1);
        end
        RUN: begin
          cyc_cnt <= cyc_inc;
          ins_cnt <= ins_inc;
          // halt takes priority over a coincident timeout
          if (!abort && (halt || timeout_hit)) begin
            res_idx     <= cur;
            res_cycles  <= cyc_inc;
            res_instrs  <= ins_inc;
            res_timeout <= !halt;
          end
        end
        REPORT: begin
          if (all_q && (cur < LAST_IDX)) begin
            cur      <= cur + IDX_W'(1);
            slen_cnt <= SL_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Self-checking bench for prog_run_ctrl: a behavioural core model drives halt/retire
// and each feature task compares logged launches/results against expected values.
module tb_prog_run_ctrl;
  localparam int ADDR_W = 8, NUM_PROGS = 4, CNT_W = 32, TOUT = 50, START_LEN = 1, IDX_W = 2;

  logic              CLK = 1'b0, reset_n = 1'b0;
  logic              cfg_we = 1'b0, go = 1'b0, run_all = 1'b0, abort = 1'b0;
  logic              halt = 1'b0, instr_retire = 1'b0;
  logic [IDX_W-1:0]  cfg_idx = '0, run_sel = '0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic              start, busy, done, res_valid, res_timeout;
  logic [ADDR_W-1:0] start_addr;
  logic [IDX_W-1:0]  res_idx;
  logic [CNT_W-1:0]  res_cycles, res_instrs;

  prog_run_ctrl #(.ADDR_W(ADDR_W), .NUM_PROGS(NUM_PROGS), .CNT_W(CNT_W), .TIMEOUT(TOUT),
                  .START_LEN(START_LEN)) dut (
    .CLK(CLK), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .go(go), .run_all(run_all), .run_sel(run_sel), .abort(abort), .halt(halt),
    .instr_retire(instr_retire), .start(start), .start_addr(start_addr), .busy(busy),
    .done(done), .res_valid(res_valid), .res_idx(res_idx), .res_cycles(res_cycles),
    .res_instrs(res_instrs), .res_timeout(res_timeout));

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_err = 0;
  int tb_cyc = 0, start_hi = 0, done_cnt = 0, done_t = 0;
  logic start_prev = 1'b0;
  logic [7:0] start_q[$];
  int res_idx_q[$], res_cyc_q[$], res_ins_q[$], res_to_q[$], res_t_q[$];
  logic [7:0] model_tab[NUM_PROGS] = '{default: 8'd0};

  initial forever begin
    @(negedge CLK);
    tb_cyc++;
    if (start) start_hi++;
    if (start && !start_prev) start_q.push_back(start_addr);
    start_prev = start;
    if (res_valid) begin
      res_idx_q.push_back(int'(res_idx)); res_cyc_q.push_back(int'(res_cycles));
      res_ins_q.push_back(int'(res_instrs)); res_to_q.push_back(int'(res_timeout));
      res_t_q.push_back(tb_cyc);
    end
    if (done) begin done_cnt++; done_t = tb_cyc; end
  end

  task automatic clear_logs();
    start_q.delete(); res_idx_q.delete(); res_cyc_q.delete(); res_ins_q.delete();
    res_to_q.delete(); res_t_q.delete(); start_hi = 0; done_cnt = 0;
  endtask

  task automatic cfg_write(input int idx, input logic [7:0] a);
    cfg_we = 1'b1; cfg_idx = idx[1:0]; cfg_addr = a;
    @(negedge CLK);
    cfg_we = 1'b0;
    model_tab[idx] = a;
  endtask

  task automatic issue_go(input bit all, input int sel);
    go = 1'b1; run_all = all; run_sel = sel[1:0];
    @(negedge CLK);
    go = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 10 && busy; t++) @(negedge CLK);
  endtask

  // Core model: waits for start, then behaves for RUN cycles 1..n. A halt_at outside
  // 1..TOUT never halts, so the run ends at the timeout with TOUT cycles.
  task automatic core_run(input int halt_at, input int nret, output int exp_cyc,
                          output int exp_ins, output bit exp_to, output bit ok);
    logic r;
    ok = 1'b0; exp_cyc = 0; exp_ins = 0; exp_to = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (start) ok = 1'b1;
      else @(negedge CLK);
    end
    if (!ok) return;
    @(negedge CLK);
    exp_to  = !(halt_at >= 1 && halt_at <= TOUT);
    exp_cyc = exp_to ? TOUT : halt_at;
    for (int k = 1; k <= exp_cyc; k++) begin
      halt = (k == halt_at);
      r = (nret < 0) ? 1'($urandom_range(0, 1)) : (k <= nret);
      instr_retire = r;
      exp_ins += int'(r);
      @(negedge CLK);
    end
    halt = 1'b0; instr_retire = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (start !== 1'b0) begin n_err++; $display("FAIL rst_start got %b want 0", start); end
    n_cmp++; if (start_addr !== 8'd0) begin n_err++; $display("FAIL rst_start_addr got %0d want 0", start_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    n_cmp++; if (res_cycles !== '0 || res_instrs !== '0 || res_idx !== '0 || res_timeout !== 1'b0) begin
      n_err++; $display("FAIL rst_res got %0d/%0d/%0d/%b want 0", res_idx, res_cycles, res_instrs, res_timeout); end
    @(negedge CLK); @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single();
    int c, i; bit to, ok;
    for (int k = 0; k < 4; k++) cfg_write(k, (k == 0) ? 8'd0 : (k == 1) ? 8'd75 : (k == 2) ? 8'd130 : 8'd200);
    clear_logs();
    issue_go(1'b0, 1);
    core_run(10, 7, c, i, to, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL single_launch got no start want start"); end
    repeat (3) @(negedge CLK);
    n_cmp++; if (start_q.size() != 1 || start_q[0] !== 8'd75) begin n_err++; $display("FAIL single_addr got n=%0d want one launch at 75", start_q.size()); end
    n_cmp++; if (start_hi != 1) begin n_err++; $display("FAIL single_start_len got %0d want 1", start_hi); end
    n_cmp++; if (res_idx_q.size() != 1) begin n_err++; $display("FAIL single_nres got %0d want 1", res_idx_q.size()); end
    else begin
      n_cmp++; if (res_idx_q[0] != 1 || res_cyc_q[0] != 10 || res_ins_q[0] != 7 || res_to_q[0] != 0) begin
        n_err++; $display("FAIL single_res got %0d/%0d/%0d/%0d want 1/10/7/0", res_idx_q[0], res_cyc_q[0], res_ins_q[0], res_to_q[0]); end
      n_cmp++; if (done_cnt != 1 || done_t != res_t_q[0] + 1) begin
        n_err++; $display("FAIL single_done got cnt=%0d t=%0d want cnt=1 t=%0d", done_cnt, done_t, res_t_q[0] + 1); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle got busy=%b want 0", busy); end
    n_cmp++; if (res_cycles !== 32'd10) begin n_err++; $display("FAIL single_hold got %0d want 10", res_cycles); end
  endtask

  task automatic test_sweep();
    int c[4], i[4]; bit to[4], ok[4];
    clear_logs();
    issue_go(1'b1, 3);
    for (int p = 0; p < 4; p++) core_run(5 + p, -1, c[p], i[p], to[p], ok[p]);
    repeat (3) @(negedge CLK);
    n_cmp++; if (start_q.size() != 4) begin n_err++; $display("FAIL sweep_nlaunch got %0d want 4", start_q.size()); end
    else for (int p = 0; p < 4; p++) begin
      n_cmp++; if (start_q[p] !== model_tab[p]) begin n_err++; $display("FAIL sweep_addr%0d got %0d want %0d", p, start_q[p], model_tab[p]); end
    end
    n_cmp++; if (res_cyc_q.size() != 4) begin n_err++; $display("FAIL sweep_nres got %0d want 4", res_cyc_q.size()); end
    else begin
      for (int p = 0; p < 4; p++) begin
        n_cmp++; if (res_idx_q[p] != p || res_cyc_q[p] != 5 + p || res_ins_q[p] != i[p] || res_to_q[p] != 0) begin
          n_err++; $display("FAIL sweep_res%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/0", p, res_idx_q[p], res_cyc_q[p], res_ins_q[p], res_to_q[p], p, 5 + p, i[p]); end
      end
      n_cmp++; if (done_cnt != 1 || done_t != res_t_q[3] + 1) begin
        n_err++; $display("FAIL sweep_done got cnt=%0d t=%0d want cnt=1 t=%0d", done_cnt, done_t, res_t_q[3] + 1); end
    end
  endtask

  task automatic test_timeout();
    int c, i; bit to, ok;
    clear_logs();
    issue_go(1'b0, 2);
    core_run(0, -1, c, i, to, ok);
    wait_idle();
    n_cmp++; if (res_cyc_q.size() != 1 || res_cyc_q[0] != TOUT || res_to_q[0] != 1 || res_ins_q[0] != i) begin
      n_err++; $display("FAIL timeout_res got n=%0d cyc=%0d to=%0d want n=1 cyc=%0d to=1 ins=%0d", res_cyc_q.size(), res_cycles, res_timeout, TOUT, i); end
    clear_logs();
    issue_go(1'b0, 2);
    core_run(TOUT, -1, c, i, to, ok);
    wait_idle();
    n_cmp++; if (res_cyc_q.size() != 1 || res_cyc_q[0] != TOUT || res_to_q[0] != 0) begin
      n_err++; $display("FAIL halt_at_limit got n=%0d cyc=%0d to=%0d want n=1 cyc=%0d to=0", res_cyc_q.size(), res_cycles, res_timeout, TOUT); end
  endtask

  task automatic test_abort_lockout();
    int c, i; bit to, ok;
    clear_logs();
    issue_go(1'b0, 3);
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_run_idle got busy=%b want 0", busy); end
    repeat (3) @(negedge CLK);
    n_cmp++; if (res_idx_q.size() != 0 || done_cnt != 0) begin n_err++; $display("FAIL abort_run_quiet got nres=%0d done=%0d want 0/0", res_idx_q.size(), done_cnt); end
    issue_go(1'b0, 1);
    abort = 1'b1;
    #1;
    n_cmp++; if (start !== 1'b0) begin n_err++; $display("FAIL abort_launch_start got %b want 0", start); end
    @(negedge CLK);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_launch_idle got busy=%b want 0", busy); end
    clear_logs();
    issue_go(1'b0, 0);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 8'd99; go = 1'b1; run_sel = 2'd2;
    core_run(4, -1, c, i, to, ok);
    cfg_we = 1'b0; go = 1'b0;
    wait_idle(); @(negedge CLK);
    n_cmp++; if (start_q.size() != 1 || res_idx_q.size() != 1) begin n_err++; $display("FAIL go_busy_ignored got launches=%0d results=%0d want 1/1", start_q.size(), res_idx_q.size()); end
    issue_go(1'b0, 0);
    n_cmp++; if (start_addr !== model_tab[0]) begin n_err++; $display("FAIL cfg_lockout got %0d want %0d", start_addr, model_tab[0]); end
    abort = 1'b1; @(negedge CLK); abort = 1'b0;
  endtask

  task automatic test_random();
    int c, i, slot, n, sel; bit to, ok, all;
    int e_slot[$], e_cyc[$], e_ins[$], e_to[$];
    for (int it = 0; it < 6; it++) begin
      cfg_write($urandom_range(0, 3), 8'($urandom_range(0, 255)));
      all = 1'($urandom_range(0, 1)); sel = $urandom_range(0, 3);
      n = all ? NUM_PROGS : 1;
      e_slot.delete(); e_cyc.delete(); e_ins.delete(); e_to.delete();
      clear_logs();
      issue_go(all, sel);
      for (int p = 0; p < n; p++) begin
        slot = all ? p : sel;
        core_run($urandom_range(1, 60), -1, c, i, to, ok);
        e_slot.push_back(slot); e_cyc.push_back(c); e_ins.push_back(i); e_to.push_back(int'(to));
      end
      wait_idle(); @(negedge CLK);
      n_cmp++; if (res_idx_q.size() != n || start_q.size() != n || done_cnt != 1) begin
        n_err++; $display("FAIL rand%0d_counts got res=%0d launch=%0d done=%0d want %0d/%0d/1", it, res_idx_q.size(), start_q.size(), done_cnt, n, n); end
      else for (int p = 0; p < n; p++) begin
        n_cmp++; if (start_q[p] !== model_tab[e_slot[p]] || res_idx_q[p] != e_slot[p] || res_cyc_q[p] != e_cyc[p] || res_ins_q[p] != e_ins[p] || res_to_q[p] != e_to[p]) begin
          n_err++; $display("FAIL rand%0d_res%0d got addr=%0d %0d/%0d/%0d/%0d want addr=%0d %0d/%0d/%0d/%0d", it, p, start_q[p], res_idx_q[p], res_cyc_q[p], res_ins_q[p], res_to_q[p],
                            model_tab[e_slot[p]], e_slot[p], e_cyc[p], e_ins[p], e_to[p]); end
      end
    end
  endtask

  task automatic test_reset_midrun();
    int c, i; bit to, ok;
    issue_go(1'b0, 1);
    @(negedge CLK);
    instr_retire = 1'b1;
    repeat (5) @(negedge CLK);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || start !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_ctrl got busy=%b start=%b done=%b vld=%b want 0", busy, start, done, res_valid); end
    n_cmp++; if (start_addr !== '0 || res_idx !== '0 || res_cycles !== '0 || res_instrs !== '0 || res_timeout !== 1'b0) begin
      n_err++; $display("FAIL midrst_data got addr=%0d %0d/%0d/%0d/%b want 0", start_addr, res_idx, res_cycles, res_instrs, res_timeout); end
    instr_retire = 1'b0;
    @(negedge CLK);
    reset_n = 1'b1;
    for (int k = 0; k < NUM_PROGS; k++) model_tab[k] = 8'd0;
    @(negedge CLK);
    clear_logs();
    issue_go(1'b0, 1);
    n_cmp++; if (start_addr !== model_tab[1]) begin n_err++; $display("FAIL midrst_table got %0d want %0d", start_addr, model_tab[1]); end
    core_run(4, 2, c, i, to, ok);
    wait_idle();
    n_cmp++; if (res_cyc_q.size() != 1 || res_cycles !== 32'd4 || res_instrs !== 32'd2 || res_timeout !== 1'b0) begin
      n_err++; $display("FAIL midrst_fresh got n=%0d cyc=%0d ins=%0d to=%b want 1/4/2/0", res_cyc_q.size(), res_cycles, res_instrs, res_timeout); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_timeout();
    test_abort_lockout();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
